hfrv_bus_arbiter: RTL and testbench

//  Shares the HF-RISC memory bus (boot ROM / RAM / peripheral decode) between the CPU and one DMA master.

---
 rtl/hfrv_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_hfrv_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_bus_arbiter.sv
// hfrv_bus_arbiter
//   Shares the HF-RISC memory bus between the CPU and a single DMA master.
//   Ownership only changes through one-cycle HANDOVER / RETURN bubbles so the
//   1-cycle-latency synchronous RAM read data always lands at the master that
//   issued the read. DMA tenures are capped at MAX_BURST beats, and the CPU is
//   guaranteed CPU_SLOT owned cycles before the DMA may take the bus again.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   CPU       | CPU owns the bus, slot_cnt counts down the guaranteed CPU slot
//   HANDOVER  | bubble: CPU's pending read data phase completes, no writes
//   DMA       | DMA owns the bus, one beat per cycle while dma_req_i is high
//   RETURN    | bubble: last DMA read data drains, then the CPU gets the bus
//
// Ports
//   clk_i, rst_i                          clock, synchronous active-high reset
//   cpu_addr_i/cpu_data_i/cpu_data_w_i    CPU bus request
//   cpu_data_o, cpu_stall_o               CPU read data and stall
//   dma_req_i/dma_addr_i/dma_data_i/
//   dma_data_w_i                          DMA bus request (we==0 means read)
//   dma_gnt_o, dma_data_o, dma_valid_o    DMA grant, read data, read-data valid
//   mem_addr_o/mem_data_o/mem_data_w_o    muxed bus request to decode/banks
//   mem_data_i                            muxed bus read data
//   mem_stall_o                           blocks every chip select this cycle
module hfrv_bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CPU_SLOT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_data_w_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_stall_o,
  input  logic        dma_req_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_data_i,
  input  logic [3:0]  dma_data_w_i,
  output logic        dma_gnt_o,
  output logic [31:0] dma_data_o,
  output logic        dma_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_data_w_o,
  input  logic [31:0] mem_data_i,
  output logic        mem_stall_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(CPU_SLOT + 1);

  localparam logic [1:0] ST_CPU      = 2'd0;
  localparam logic [1:0] ST_HANDOVER = 2'd1;
  localparam logic [1:0] ST_DMA      = 2'd2;
  localparam logic [1:0] ST_RETURN   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] slot_cnt;
  logic          dma_beat;
  logic          last_beat;
  logic          slot_done;

  assign dma_beat  = (state == ST_DMA) && dma_req_i;
  assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
  // The slot is over once this cycle's decrement brings the count to zero,
  // so the CPU owns the bus for exactly CPU_SLOT cycles after RETURN.
  assign slot_done = (slot_cnt <= SW'(1));

  // Read data is shared; ownership is qualified by cpu_stall_o / dma_valid_o.
  assign cpu_data_o = mem_data_i;
  assign dma_data_o = mem_data_i;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CPU:      if (dma_req_i && slot_done) state_nxt = ST_HANDOVER;
      ST_HANDOVER: state_nxt = ST_DMA;
      ST_DMA:      if (!dma_req_i || last_beat) state_nxt = ST_RETURN;
      ST_RETURN:   state_nxt = ST_CPU;
      default:     state_nxt = ST_CPU;
    endcase
  end

  always_comb begin
    mem_addr_o   = cpu_addr_i;
    mem_data_o   = cpu_data_i;
    mem_data_w_o = cpu_data_w_i;
    mem_stall_o  = 1'b0;
    cpu_stall_o  = 1'b0;
    dma_gnt_o    = 1'b0;
    case (state)
      ST_CPU: ;
      ST_HANDOVER: begin
        cpu_stall_o  = 1'b1;
        mem_stall_o  = 1'b1;
        mem_data_w_o = 4'b0000;
      end
      ST_DMA: begin
        cpu_stall_o  = 1'b1;
        dma_gnt_o    = 1'b1;
        mem_addr_o   = dma_addr_i;
        mem_data_o   = dma_data_i;
        if (dma_req_i) begin
          mem_data_w_o = dma_data_w_i;
        end else begin
          mem_data_w_o = 4'b0000;
          mem_stall_o  = 1'b1;
        end
      end
      ST_RETURN: begin
        cpu_stall_o  = 1'b1;
        mem_stall_o  = 1'b1;
        mem_addr_o   = dma_addr_i;
        mem_data_o   = dma_data_i;
        mem_data_w_o = 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_CPU;
      beat_cnt    <= '0;
      slot_cnt    <= '0;
      dma_valid_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      dma_valid_o <= dma_beat && (dma_data_w_i == 4'b0000);
      case (state)
        ST_CPU:      if (slot_cnt != '0) slot_cnt <= slot_cnt - SW'(1);
        ST_HANDOVER: beat_cnt <= '0;
        ST_DMA:      if (dma_req_i && (beat_cnt != BW'(MAX_BURST))) beat_cnt <= beat_cnt + BW'(1);
        ST_RETURN:   slot_cnt <= SW'(CPU_SLOT);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hfrv_bus_arbiter.sv
module tb_hfrv_bus_arbiter;

  localparam int MAX_BURST = 8;
  localparam int CPU_SLOT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_data;
  logic [3:0]  cpu_w;
  logic [31:0] cpu_data_o;
  logic        cpu_stall_o;
  logic        dma_req;
  logic [31:0] dma_addr, dma_data;
  logic [3:0]  dma_w;
  logic        dma_gnt_o;
  logic [31:0] dma_data_o;
  logic        dma_valid_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [3:0]  mem_data_w_o;
  logic [31:0] mem_rdata;
  logic        mem_stall_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [256];

  always #5 clk = ~clk;

  hfrv_bus_arbiter #(.MAX_BURST(MAX_BURST), .CPU_SLOT(CPU_SLOT)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data), .cpu_data_w_i(cpu_w),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req), .dma_addr_i(dma_addr), .dma_data_i(dma_data),
    .dma_data_w_i(dma_w), .dma_gnt_o(dma_gnt_o), .dma_data_o(dma_data_o),
    .dma_valid_o(dma_valid_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_w_o(mem_data_w_o),
    .mem_data_i(mem_rdata), .mem_stall_o(mem_stall_o)
  );

  // Synchronous RAM with one-cycle read latency and byte write enables.
  logic [31:0] ram [256];
  logic        ram_ready = 1'b0;

  function automatic logic [31:0] pattern(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0107);
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= pattern(i);
      ram_ready <= 1'b1;
    end else if (!mem_stall_o) begin
      mem_rdata <= ram[mem_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_data_w_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    end
  end

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      dma_req = 1'b0;
      cpu_w   = 4'b0000;
    end
  endtask

  // One DMA tenure of n beats (1..MAX_BURST). Expected behaviour follows from
  // the bus rules: HANDOVER + n beats (+ one empty DMA cycle if n < MAX_BURST)
  // + RETURN stall the CPU; every read beat yields a valid pulse one cycle later.
  task automatic run_burst(input string name, input int n, input logic [31:0] base,
                           input logic [3:0] we, input logic [31:0] seed);
    int beats = 0;
    int stalls = 0;
    bit seen = 0;
    bit done = 0;
    bit pend = 0;
    logic [31:0] pend_data = '0;
    int exp_stalls;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      dma_req  = (beats < n);
      dma_addr = base + 32'(beats * 4);
      dma_data = seed ^ 32'(beats);
      dma_w    = we;
      #1;
      checks++;
      if (dma_valid_o !== pend) begin
        errors++;
        $display("FAIL %s valid cyc %0d: got %b want %b", name, cyc, dma_valid_o, pend);
      end
      if (pend) begin
        checks++;
        if (dma_data_o !== pend_data) begin
          errors++;
          $display("FAIL %s rdata: got %h want %h", name, dma_data_o, pend_data);
        end
      end
      pend = 1'b0;
      if (cpu_stall_o) begin
        stalls++;
        seen = 1'b1;
      end
      if (cpu_stall_o && !dma_gnt_o) begin
        checks++;
        if (mem_stall_o !== 1'b1 || mem_data_w_o !== 4'b0000) begin
          errors++;
          $display("FAIL %s bubble: mem_stall %b we %b want 1 0000", name, mem_stall_o, mem_data_w_o);
        end
      end
      if (dma_gnt_o && dma_req) begin
        checks++;
        if (mem_addr_o !== dma_addr || mem_data_w_o !== we || mem_stall_o !== 1'b0) begin
          errors++;
          $display("FAIL %s beat: addr %h we %b stall %b want %h %b 0", name,
                   mem_addr_o, mem_data_w_o, mem_stall_o, dma_addr, we);
        end
        if (we == 4'b0000) begin
          pend      = 1'b1;
          pend_data = exp_mem[dma_addr[9:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (we[b]) exp_mem[dma_addr[9:2]][8*b +: 8] = dma_data[8*b +: 8];
        end
        beats++;
      end
      if (seen && !cpu_stall_o) done = 1'b1;
    end
    dma_req = 1'b0;
    exp_stalls = (n >= MAX_BURST) ? MAX_BURST + 2 : n + 3;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: tenure did not finish", name);
    end
    checks++;
    if (beats != n || stalls != exp_stalls) begin
      errors++;
      $display("FAIL %s counts: beats %0d stalls %0d want %0d %0d", name, beats, stalls, n, exp_stalls);
    end
  endtask

  task automatic cpu_read(input string name, input logic [31:0] addr);
    @(negedge clk);
    dma_req  = 1'b0;
    cpu_addr = addr;
    cpu_w    = 4'b0000;
    #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || mem_addr_o !== addr) begin
      errors++;
      $display("FAIL %s cpu issue: stall %b addr %h want 0 %h", name, cpu_stall_o, mem_addr_o, addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_data_o !== exp_mem[addr[9:2]]) begin
      errors++;
      $display("FAIL %s cpu rdata: got %h want %h", name, cpu_data_o, exp_mem[addr[9:2]]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (cpu_stall_o !== 1'b0 || dma_gnt_o !== 1'b0 || dma_valid_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: stall %b gnt %b valid %b mstall %b want 0 0 0 0",
               cpu_stall_o, dma_gnt_o, dma_valid_o, mem_stall_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cpu_only;
    logic [31:0] prev = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      dma_req  = 1'b0;
      cpu_addr = 32'h4000_0000 + 32'(4 * (i % 8));
      #1;
      checks++;
      if (cpu_stall_o !== 1'b0 || dma_gnt_o !== 1'b0 || mem_addr_o !== cpu_addr) begin
        errors++;
        $display("FAIL cpu_only cyc %0d: stall %b gnt %b addr %h want 0 0 %h",
                 i, cpu_stall_o, dma_gnt_o, mem_addr_o, cpu_addr);
      end
      if (i > 0) begin
        checks++;
        if (cpu_data_o !== exp_mem[prev[9:2]]) begin
          errors++;
          $display("FAIL cpu_only rdata: got %h want %h", cpu_data_o, exp_mem[prev[9:2]]);
        end
      end
      prev = cpu_addr;
    end
  endtask

  task automatic test_dma_read3;
    idle(CPU_SLOT);
    run_burst("dma_read3", 3, 32'h4000_0000, 4'b0000, 32'h0);
  endtask

  task automatic test_back_to_back;
    int tot = 1 + (MAX_BURST + 2) + CPU_SLOT + 1;
    int beats = 0;
    bit want;
    idle(CPU_SLOT);
    for (int i = 0; i < tot; i++) begin
      @(negedge clk);
      dma_req  = 1'b1;
      dma_addr = 32'h4000_0000;
      dma_w    = 4'b0000;
      #1;
      want = (i >= 1 && i <= MAX_BURST + 2) || (i == tot - 1);
      checks++;
      if (cpu_stall_o !== want) begin
        errors++;
        $display("FAIL back_to_back stall cyc %0d: got %b want %b", i, cpu_stall_o, want);
      end
      if (i <= MAX_BURST + 2 && dma_gnt_o) beats++;
    end
    checks++;
    if (beats != MAX_BURST) begin
      errors++;
      $display("FAIL back_to_back beats: got %0d want %0d", beats, MAX_BURST);
    end
    // Request drops in HANDOVER: DMA entered, exits with no beat.
    begin
      bit cleared = 0;
      for (int i = 0; i < 10 && !cleared; i++) begin
        @(negedge clk);
        dma_req = 1'b0;
        #1;
        if (!cpu_stall_o) cleared = 1'b1;
      end
      checks++;
      if (!cleared) begin
        errors++;
        $display("FAIL back_to_back drain: stall still %b", cpu_stall_o);
      end
    end
  endtask

  task automatic test_dma_write;
    idle(CPU_SLOT);
    run_burst("dma_write_full", 1, 32'h4000_0100, 4'b1111, 32'hDEAD_BEEF);
    cpu_read("dma_write_full", 32'h4000_0100);
    checks++;
    if (exp_mem[64] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL dma_write_full model: got %h want deadbeef", exp_mem[64]);
    end
    idle(CPU_SLOT);
    run_burst("dma_write_byte", 1, 32'h4000_0100, 4'b0010, 32'h0000_AB00);
    cpu_read("dma_write_byte", 32'h4000_0100);
    checks++;
    if (exp_mem[64] !== 32'hDEAD_ABEF) begin
      errors++;
      $display("FAIL dma_write_byte model: got %h want deadabef", exp_mem[64]);
    end
  endtask

  task automatic test_reset_mid_tenure;
    int beats = 0;
    bit hit = 0;
    idle(CPU_SLOT);
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      dma_req  = 1'b1;
      dma_addr = 32'h4000_0000 + 32'(4 * beats);
      dma_w    = 4'b0000;
      #1;
      if (dma_gnt_o) begin
        if (beats == 2) begin
          rst = 1'b1;
          hit = 1'b1;
        end
        beats++;
      end
    end
    @(negedge clk);
    rst     = 1'b0;
    dma_req = 1'b0;
    #1;
    checks++;
    if (!hit || dma_gnt_o !== 1'b0 || dma_valid_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid hit %b: gnt %b valid %b stall %b mstall %b want 0 0 0 0",
               hit, dma_gnt_o, dma_valid_o, cpu_stall_o, mem_stall_o);
    end
    cpu_read("reset_mid", 32'h4000_0008);
  endtask

  task automatic test_random;
    for (int t = 0; t < 12; t++) begin
      int n = int'($urandom_range(1, MAX_BURST));
      logic [31:0] base = 32'h4000_0000 + 32'(4 * $urandom_range(0, 200));
      logic [3:0] we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      logic [31:0] seed = $urandom;
      idle(CPU_SLOT);
      run_burst("random", n, base, we, seed);
      cpu_read("random", base);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_addr = 32'h4000_0000; cpu_data = '0; cpu_w = '0;
    dma_req = 1'b0; dma_addr = 32'h4000_0000; dma_data = '0; dma_w = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = pattern(i);
    test_reset;
    test_cpu_only;
    test_dma_read3;
    test_back_to_back;
    test_dma_write;
    test_reset_mid_tenure;
    test_random;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
